// File: rtl/lsu_pkg.sv
// Shared types and funct3 decode helpers for the load/store unit and its bench.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, MEM, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Only the low two funct3 bits encode the access size.
  function automatic lsu_size_t f3_size(input logic [1:0] f3_lo);
    lsu_size_t sz;
    case (f3_lo)
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Unsigned variants exist only for loads; stores accept b/h/w.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the execute stage and the load/store unit.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Sign- or zero-extends a zero-padded memory read word according to the load funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] ext
);

  always_comb begin
    ext = '0;
    case (funct3)
      F3_B:    ext = {{(WIDTH-8){raw[7]}}, raw[7:0]};
      F3_H:    ext = {{(WIDTH-16){raw[15]}}, raw[15:0]};
      F3_W:    ext = raw;
      F3_BU:   ext = {{(WIDTH-8){1'b0}}, raw[7:0]};
      F3_HU:   ext = {{(WIDTH-16){1'b0}}, raw[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for the byte-addressed data memory: decodes and checks one
// request at a time, drives registered memory strobes, and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 20
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [DEPTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              mem_one_byte,
  output logic              mem_two_bytes,
  output logic              mem_four_bytes,
  input  logic [WIDTH-1:0]  mem_data_out
);

  lsu_state_t       state;
  lsu_state_t       state_next;
  lsu_size_t        req_size;
  logic             req_fault;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] load_ext;
  logic [WIDTH-1:0] resp_rdata_q;
  logic             resp_err_q;

  always_comb begin
    req_size  = f3_size(bus.req_funct3[1:0]);
    req_fault = !f3_legal(bus.req_we, bus.req_funct3)
              || (req_size == SZ_H && bus.req_addr[0])
              || (req_size == SZ_W && bus.req_addr[1:0] != 2'b00)
              || (bus.req_addr[WIDTH-1:DEPTH] != '0);
  end

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Faulty requests skip MEM entirely so the memory never sees them.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = req_fault ? RESP : MEM;
      MEM:     state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_load_extend #(.WIDTH(WIDTH)) u_extend (
    .funct3 (funct3_q),
    .raw    (mem_data_out),
    .ext    (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      funct3_q       <= '0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      mem_addr       <= '0;
      mem_data_in    <= '0;
      mem_wr         <= 1'b0;
      mem_rd         <= 1'b0;
      mem_one_byte   <= 1'b0;
      mem_two_bytes  <= 1'b0;
      mem_four_bytes <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            if (req_fault) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              mem_addr       <= bus.req_addr[DEPTH-1:0];
              mem_data_in    <= bus.req_wdata;
              mem_wr         <= bus.req_we;
              mem_rd         <= !bus.req_we;
              mem_one_byte   <= (req_size == SZ_B);
              mem_two_bytes  <= (req_size == SZ_H);
              mem_four_bytes <= (req_size == SZ_W);
            end
          end
        end
        // The memory acted on the falling edge inside this cycle, so its word is ready now.
        MEM: begin
          mem_wr         <= 1'b0;
          mem_rd         <= 1'b0;
          mem_one_byte   <= 1'b0;
          mem_two_bytes  <= 1'b0;
          mem_four_bytes <= 1'b0;
          resp_err_q     <= 1'b0;
          resp_rdata_q   <= we_q ? '0 : load_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential load/store front end sitting directly upstream of the byte-addressed data memory.
- Accepts one RV32 load/store request at a time from the execute stage over a valid/ready handshake.
- Decodes funct3 into the memory's rd/wr and size strobes, and checks alignment and address range.
- Captures the memory's read word, sign- or zero-extends it, and returns a response over a second valid/ready handshake.

Parameters:
- WIDTH, 32, data and request-address width.
- DEPTH, 20, memory address bits; must be < WIDTH.

Ports:
- clk  in  1  clock; the memory array acts on the falling edge, this block on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- mem_addr  out  DEPTH  to memory addr
- mem_data_in  out  WIDTH  to memory data_in
- mem_wr, mem_rd  out  1 each  memory strobes
- mem_one_byte, mem_two_bytes, mem_four_bytes  out  1 each  size strobes; exactly one high while mem_wr or mem_rd is high
- mem_data_out  in  WIDTH  memory read word, zero-padded above access size

Behaviour:
- FSM states: IDLE, MEM, RESP.
- req_ready = (state == IDLE) && !rst. resp_valid is high only in RESP.
- Reset (synchronous, rst high at a rising edge):
  - state goes to IDLE.
  - resp_valid, resp_rdata, resp_err, all mem_* strobes, mem_addr and mem_data_in are 0.
  - Reset mid-operation abandons the request with no response. A store already in MEM has been committed at the preceding falling edge; this is acceptable.
- Request accept (IDLE, req_valid at rising edge):
  - Register the address, data, we and funct3.
  - Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw. Any other funct3 is illegal.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: req_addr[WIDTH-1:DEPTH] != 0.
  - Any fault: go to RESP with resp_err = 1 and resp_rdata = 0. No mem strobe is ever asserted. Latency is 1 edge.
  - Otherwise: go to MEM and drive mem_addr = addr[DEPTH-1:0], mem_data_in = wdata, mem_rd = !we, mem_wr = we, plus the size strobe. Strobes are registered and stable for the whole MEM cycle.
- MEM (exactly one cycle; the memory performs the access at its falling edge). At the next rising edge:
  - Clear all strobes.
  - For a load, capture mem_data_out and extend it:
    - lb sign-extends bit 7; lh sign-extends bit 15.
    - lbu and lhu zero-extend; lw passes the word through.
  - For a store, resp_rdata = 0.
  - resp_err = 0; go to RESP. Response latency is 2 edges after accept.
- RESP:
  - Hold resp_valid, resp_rdata and resp_err stable until resp_ready is high at a rising edge, then go to IDLE and clear resp_valid.
  - Back-pressure may be indefinite.
  - The next request can be accepted one edge after the response handshake, so peak throughput is 1 per 3 cycles.
- req_valid high while req_ready is low is ignored, not queued.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_t enum {IDLE, MEM, RESP}.
  - funct3 localparams F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - size enum {SZ_B, SZ_H, SZ_W}.
- One sub-module, lsu_load_extend: combinational, (funct3, raw word) -> extended word. It is reused in the bench scoreboard.

Test Plan:
- sw: addr 0x100, wdata 0xDEADBEEF, then lw 0x100 -> store response err 0, rdata 0. Load resp_rdata 0xDEADBEEF exactly 2 edges after accept; mem_rd and mem_four_bytes high for one cycle only.
- Extension: sb 0x80 to 0x10, then lb 0x10 -> 0xFFFFFF80 and lbu 0x10 -> 0x00000080. sh 0x8001 to 0x20, then lh -> 0xFFFF8001 and lhu -> 0x00008001.
- Faults, all giving resp_err 1, rdata 0, 1-edge latency, and no mem strobe in any cycle:
  - lw at 0x102 (misaligned);
  - sh at 0x21 (misaligned);
  - lw at 0x0010_0000 with DEPTH = 20 (out of range);
  - funct3 011 (illegal).
- Back-pressure: hold resp_ready low 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready low, a second req_valid is ignored. Raise resp_ready -> IDLE, then the second request is accepted.
- Reset in MEM during lw -> next edge: IDLE, all strobes 0, resp_valid never asserted; req_ready is 1 after rst is released.
- Random sequence of 1000 legal and illegal requests with random resp_ready -> responses match a byte-array reference model built on lsu_load_extend.
